// File: rtl/uart_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_pkg                                                                 |
// | Parity constants, checker state encoding and shared parity function.     |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
package uart_pkg;

   localparam logic [1:0] PAR_EVEN  = 2'b00;
   localparam logic [1:0] PAR_ODD   = 2'b01;
   localparam logic [1:0] PAR_SPACE = 2'b10;
   localparam logic [1:0] PAR_MARK  = 2'b11;

   typedef enum logic [1:0] {
      CHK_IDLE = 2'b00,
      CHK_DATA = 2'b01,
      CHK_PAR  = 2'b10,
      CHK_DONE = 2'b11
   } chk_state_e;

   // acc is the XOR of all data bits; a disabled parity always yields 0.
   function automatic logic par_expect(input logic acc, input logic [1:0] mode, input logic en);
      logic p;
      p = 1'b0;
      if (en) begin
         case (mode)
            PAR_EVEN:  p = acc;
            PAR_ODD:   p = ~acc;
            PAR_SPACE: p = 1'b0;
            default:   p = 1'b1;
         endcase
      end
      return p;
   endfunction

endpackage
`default_nettype wire

// File: rtl/uart_parity_chk.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_parity_chk                                                          |
// | Bit-serial RX parity checker FSM with done/error pulses.                 |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_parity_chk
   import uart_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       parity_en,
   input  logic [1:0] parity_mode,
   input  logic       rx_start,
   input  logic       rx_bit_valid,
   input  logic       rx_bit,
   output logic       rx_done,
   output logic       rx_par_err
);

   localparam int               CNT_W    = $clog2(DATA_W + 1);
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   chk_state_e       state_q;
   logic             acc_q;
   logic [CNT_W-1:0] bit_cnt_q;
   logic             en_q;
   logic [1:0]       mode_q;
   logic             done_q;
   logic             err_q;

   // done/err are raised on the edge that enters DONE, so they are high exactly
   // while the FSM sits in DONE.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= CHK_IDLE;
         acc_q     <= 1'b0;
         bit_cnt_q <= '0;
         en_q      <= 1'b0;
         mode_q    <= 2'b00;
         done_q    <= 1'b0;
         err_q     <= 1'b0;
      end else begin
         done_q <= 1'b0;
         err_q  <= 1'b0;
         if (rx_start) begin
            state_q   <= CHK_DATA;
            acc_q     <= 1'b0;
            bit_cnt_q <= '0;
            en_q      <= parity_en;
            mode_q    <= parity_mode;
         end else begin
            case (state_q)
               CHK_DATA: begin
                  if (rx_bit_valid) begin
                     acc_q     <= acc_q ^ rx_bit;
                     bit_cnt_q <= bit_cnt_q + 1'b1;
                     if (bit_cnt_q == LAST_BIT) begin
                        if (en_q) begin
                           state_q <= CHK_PAR;
                        end else begin
                           state_q <= CHK_DONE;
                           done_q  <= 1'b1;
                        end
                     end
                  end
               end
               CHK_PAR: begin
                  if (rx_bit_valid) begin
                     state_q <= CHK_DONE;
                     done_q  <= 1'b1;
                     err_q   <= (rx_bit != par_expect(acc_q, mode_q, en_q));
                  end
               end
               CHK_DONE: state_q <= CHK_IDLE;
               default:  state_q <= CHK_IDLE;
            endcase
         end
      end
   end

   assign rx_done    = done_q;
   assign rx_par_err = err_q;

endmodule
`default_nettype wire

// File: rtl/uart_parity_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | uart_parity_unit                                                         |
// | UART parity generator (TX, 1-cycle latency) and serial checker (RX).     |
// | Optional saturating error counter: define PARITY_ERR_CNT_EN.             |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module uart_parity_unit
   import uart_pkg::*;
#(
   parameter int DATA_W = 8
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              parity_en,
   input  logic [1:0]        parity_mode,
   input  logic              tx_valid,
   input  logic [DATA_W-1:0] tx_data,
   output logic              tx_par_bit,
   output logic              tx_par_valid,
   input  logic              rx_start,
   input  logic              rx_bit_valid,
   input  logic              rx_bit,
`ifdef PARITY_ERR_CNT_EN
   output logic [7:0]        err_count,
   input  logic              err_clr,
`endif
   output logic              rx_done,
   output logic              rx_par_err
);

   logic tx_par_bit_q;
   logic tx_par_valid_q;

   // The parity bit is computed at acceptance and held until the next frame.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tx_par_bit_q   <= 1'b0;
         tx_par_valid_q <= 1'b0;
      end else begin
         tx_par_valid_q <= tx_valid;
         if (tx_valid) begin
            tx_par_bit_q <= par_expect(^tx_data, parity_mode, parity_en);
         end
      end
   end

   assign tx_par_bit   = tx_par_bit_q;
   assign tx_par_valid = tx_par_valid_q;

   uart_parity_chk #(
      .DATA_W       (DATA_W)
   ) u_chk (
      .clk          (clk),
      .rst          (rst),
      .parity_en    (parity_en),
      .parity_mode  (parity_mode),
      .rx_start     (rx_start),
      .rx_bit_valid (rx_bit_valid),
      .rx_bit       (rx_bit),
      .rx_done      (rx_done),
      .rx_par_err   (rx_par_err)
   );

`ifdef PARITY_ERR_CNT_EN
   logic [7:0] err_count_q;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         err_count_q <= 8'd0;
      end else if (err_clr) begin
         err_count_q <= 8'd0;
      end else if (rx_par_err && (err_count_q != 8'hFF)) begin
         err_count_q <= err_count_q + 8'd1;
      end
   end

   assign err_count = err_count_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_uart_parity_unit.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | tb_uart_parity_unit                                                      |
// | Directed bench with a behavioural reference model and per-cycle compare. |
// | Rev 1.0                                                                  |
// +--------------------------------------------------------------------------+
module tb_uart_parity_unit;
   import uart_pkg::*;

   localparam int DATA_W = 8;

   logic              clk = 1'b0;
   logic              rst;
   logic              parity_en;
   logic [1:0]        parity_mode;
   logic              tx_valid;
   logic [DATA_W-1:0] tx_data;
   logic              tx_par_bit;
   logic              tx_par_valid;
   logic              rx_start;
   logic              rx_bit_valid;
   logic              rx_bit;
   logic              rx_done;
   logic              rx_par_err;
`ifdef PARITY_ERR_CNT_EN
   logic [7:0]        err_count;
   logic              err_clr;
`endif

   always #5 clk = ~clk;

   uart_parity_unit #(.DATA_W(DATA_W)) dut (
      .clk          (clk),
      .rst          (rst),
      .parity_en    (parity_en),
      .parity_mode  (parity_mode),
      .tx_valid     (tx_valid),
      .tx_data      (tx_data),
      .tx_par_bit   (tx_par_bit),
      .tx_par_valid (tx_par_valid),
      .rx_start     (rx_start),
      .rx_bit_valid (rx_bit_valid),
      .rx_bit       (rx_bit),
`ifdef PARITY_ERR_CNT_EN
      .err_count    (err_count),
      .err_clr      (err_clr),
`endif
      .rx_done      (rx_done),
      .rx_par_err   (rx_par_err)
   );

   int total = 0;
   int bad = 0;
   int done_seen = 0;
   bit chk_on = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit ref_par(input int ones, input bit [1:0] mode, input bit en);
      if (!en) return 1'b0;
      case (mode)
         2'd0:    return (ones % 2) == 1;
         2'd1:    return (ones % 2) == 0;
         2'd2:    return 1'b0;
         default: return 1'b1;
      endcase
   endfunction

   // Reference model: frame-level view of the RX stream, word-level view of TX.
   bit              m_tx_v, m_tx_b, m_done, m_err, m_active, m_en;
   bit [1:0]        m_mode;
   bit [DATA_W-1:0] m_data;
   int              m_n;
   int              m_cnt;

   initial forever begin
      @(posedge clk or negedge rst);
      if (!rst) begin
         m_tx_v = 0; m_tx_b = 0; m_done = 0; m_err = 0; m_active = 0;
         m_en = 0; m_mode = 0; m_data = 0; m_n = 0; m_cnt = 0;
      end else begin
`ifdef PARITY_ERR_CNT_EN
         if (err_clr) m_cnt = 0;
         else if (m_err && m_cnt < 255) m_cnt = m_cnt + 1;
`endif
         m_tx_v = tx_valid;
         if (tx_valid) m_tx_b = ref_par($countones(tx_data), parity_mode, parity_en);
         m_done = 0;
         m_err  = 0;
         if (rx_start) begin
            m_active = 1; m_en = parity_en; m_mode = parity_mode; m_n = 0; m_data = 0;
         end else if (m_active && rx_bit_valid) begin
            if (m_n < DATA_W) begin
               m_data[m_n] = rx_bit;
               m_n++;
               if (m_n == DATA_W && !m_en) begin
                  m_done = 1; m_active = 0;
               end
            end else begin
               m_done = 1;
               m_err = (rx_bit != ref_par($countones(m_data), m_mode, 1'b1));
               m_active = 0;
            end
         end
      end
   end

   initial forever begin
      @(negedge clk);
      if (chk_on) begin
         check("tx_par_valid", tx_par_valid, m_tx_v);
         check("tx_par_bit",   tx_par_bit,   m_tx_b);
         check("rx_done",      rx_done,      m_done);
         check("rx_par_err",   rx_par_err,   m_err);
`ifdef PARITY_ERR_CNT_EN
         check("err_count",    err_count,    m_cnt);
`endif
      end
      if (rx_done === 1'b1) done_seen++;
   end

   task automatic send_tx(input logic [DATA_W-1:0] d, input logic en, input logic [1:0] mode);
      @(negedge clk);
      tx_valid = 1; tx_data = d; parity_en = en; parity_mode = mode;
      @(negedge clk);
      tx_valid = 0; tx_data = ~d; parity_mode = ~mode;
   endtask

   // Ends at the negedge right after the last bit's clock edge; parity inputs
   // are scrambled mid-frame to show they are latched at rx_start.
   task automatic rx_frame(input logic [DATA_W-1:0] d, input logic en, input logic [1:0] mode,
                           input logic pbit, input int gap);
      @(negedge clk);
      rx_start = 1; parity_en = en; parity_mode = mode;
      @(negedge clk);
      rx_start = 0; parity_en = ~en; parity_mode = ~mode;
      for (int i = 0; i < DATA_W; i++) begin
         rx_bit_valid = 1; rx_bit = d[i];
         @(negedge clk);
         if (gap > 0 && (i < DATA_W - 1 || en)) begin
            rx_bit_valid = 0; rx_bit = ~rx_bit;
            repeat (gap) @(negedge clk);
         end
      end
      if (en) begin
         rx_bit_valid = 1; rx_bit = pbit;
         @(negedge clk);
      end
      rx_bit_valid = 0;
   endtask

   initial begin
      int d0;
      rst = 0; parity_en = 0; parity_mode = 0; tx_valid = 0; tx_data = 0;
      rx_start = 0; rx_bit_valid = 0; rx_bit = 0;
`ifdef PARITY_ERR_CNT_EN
      err_clr = 0;
`endif
      repeat (2) @(negedge clk);
      chk_on = 1;
      check("reset_tx_par_valid", tx_par_valid, 0);
      check("reset_tx_par_bit",   tx_par_bit,   0);
      check("reset_rx_done",      rx_done,      0);
      check("reset_rx_par_err",   rx_par_err,   0);
      rst = 1;

      send_tx(8'hA5, 1, PAR_EVEN);
      check("tx_even_a5_valid", tx_par_valid, 1);
      check("tx_even_a5_bit",   tx_par_bit,   0);
      send_tx(8'hA5, 1, PAR_ODD);
      check("tx_odd_a5_bit",    tx_par_bit,   1);
      send_tx(8'h00, 1, PAR_MARK);
      check("tx_mark_bit",      tx_par_bit,   1);
      send_tx(8'h00, 1, PAR_SPACE);
      check("tx_space_bit",     tx_par_bit,   0);
      send_tx(8'h01, 1, PAR_MARK);
      send_tx(8'h01, 0, PAR_MARK);
      check("tx_disabled_valid", tx_par_valid, 1);
      check("tx_disabled_bit",   tx_par_bit,   0);

      // back-to-back accepted frames
      @(negedge clk);
      tx_valid = 1; parity_en = 1; parity_mode = PAR_EVEN; tx_data = 8'h01;
      @(negedge clk); tx_data = 8'h03;
      @(negedge clk); tx_data = 8'h07; parity_mode = PAR_ODD;
      @(negedge clk); tx_valid = 0;
      repeat (2) @(negedge clk);
      check("tx_hold_after_b2b", tx_par_bit, 0);

      rx_frame(8'h07, 1, PAR_EVEN, 1, 0);
      check("rx_even_good_done", rx_done, 1);
      check("rx_even_good_err",  rx_par_err, 0);
      rx_frame(8'h07, 1, PAR_EVEN, 0, 2);
      check("rx_even_bad_done", rx_done, 1);
      check("rx_even_bad_err",  rx_par_err, 1);
      rx_frame(8'hFF, 0, PAR_ODD, 0, 0);
      check("rx_nopar_done", rx_done, 1);
      check("rx_nopar_err",  rx_par_err, 0);
      rx_frame(8'h5A, 1, PAR_MARK, 0, 1);
      check("rx_mark_bad_err", rx_par_err, 1);
      rx_frame(8'hC3, 1, PAR_ODD, 1, 0);
      check("rx_odd_good_err", rx_par_err, 0);

      // abort after 4 bits; restart coincides with a valid bit
      d0 = done_seen;
      @(negedge clk);
      rx_start = 1; parity_en = 1; parity_mode = PAR_EVEN;
      @(negedge clk);
      rx_start = 0;
      for (int i = 0; i < 4; i++) begin
         rx_bit_valid = 1; rx_bit = 1'(i);
         @(negedge clk);
      end
      rx_frame(8'h81, 1, PAR_EVEN, 0, 0);
      repeat (3) @(negedge clk);
      check("abort_one_done", done_seen - d0, 1);

      // asynchronous reset mid-frame
      send_tx(8'h00, 1, PAR_MARK);
      @(negedge clk);
      rx_start = 1; parity_en = 1; parity_mode = PAR_EVEN;
      @(negedge clk);
      rx_start = 0;
      for (int i = 0; i < 3; i++) begin
         rx_bit_valid = 1; rx_bit = 1;
         @(negedge clk);
      end
      d0 = done_seen;
      #2 rst = 0;
      @(negedge clk);
      check("midrst_tx_par_bit", tx_par_bit, 0);
      check("midrst_rx_done",    rx_done,    0);
      #2 rst = 1;
      for (int i = 0; i < 10; i++) begin
         rx_bit_valid = 1; rx_bit = 0;
         @(negedge clk);
      end
      rx_bit_valid = 0;
      repeat (2) @(negedge clk);
      check("midrst_no_done", done_seen - d0, 0);

`ifdef PARITY_ERR_CNT_EN
      for (int f = 0; f < 300; f++) rx_frame(8'h01, 1, PAR_EVEN, 0, 0);
      @(negedge clk);
      check("errcnt_saturated", err_count, 255);
      rx_frame(8'h01, 1, PAR_EVEN, 0, 0);
      err_clr = 1;
      @(negedge clk);
      err_clr = 0;
      check("errcnt_clr_wins", err_count, 0);
      rx_frame(8'h03, 1, PAR_ODD, 0, 0);
      repeat (2) @(negedge clk);
      check("errcnt_one", err_count, 1);
`endif

      repeat (3) @(negedge clk);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
`default_nettype wire
